// File: rtl/block_buffer_8x8_if.sv
// block_buffer_8x8_if: sample streams into and out of the 8x8 ping-pong block buffer.
// The slave view belongs to the buffer. The master view belongs to whatever drives
// it: the level shifter on the input side and the DCT on the output side.
interface block_buffer_8x8_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_y;
  logic signed [DATA_W-1:0] in_cb;
  logic signed [DATA_W-1:0] in_cr;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_y;
  logic signed [DATA_W-1:0] out_cb;
  logic signed [DATA_W-1:0] out_cr;
  logic [2:0]               out_row;
  logic [2:0]               out_col;
  logic                     out_last;
  logic                     block_done;
  logic [1:0]               occupancy;

  modport slave (
    input  in_valid, in_y, in_cb, in_cr, out_ready,
    output in_ready, out_valid, out_y, out_cb, out_cr,
           out_row, out_col, out_last, block_done, occupancy
  );

  modport master (
    output in_valid, in_y, in_cb, in_cr, out_ready,
    input  in_ready, out_valid, out_y, out_cb, out_cr,
           out_row, out_col, out_last, block_done, occupancy
  );
endinterface

// File: rtl/block_buffer_8x8.sv
// block_buffer_8x8: collects raster-order 8x8 blocks of {Y,Cb,Cr} samples into
// two banks. Each finished block is replayed to the DCT in row- or column-major
// order. One bank fills while the other drains, so the buffer sustains one
// sample per cycle.
module block_buffer_8x8 #(
  parameter int DATA_W         = 8,
  parameter bit READ_COL_MAJOR = 1'b0
) (
  input logic               clk,
  input logic               rst,
  block_buffer_8x8_if.slave bus
);
  localparam int SMP_W = 3 * DATA_W;

  // Address layout: {bank, row, col}. Contents are never reset.
  logic [SMP_W-1:0] mem_q [0:127];

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic       block_done_q, block_done_d;
  logic [1:0] occupancy_q, occupancy_d;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             wr_fire_s;
  logic             rd_fire_s;
  logic [2:0]       rd_row_s;
  logic [2:0]       rd_col_s;
  logic [SMP_W-1:0] rd_data_s;

  // Handshake qualifiers come straight from the bank full flags.
  always_comb begin
    in_ready_s  = ~full_q[wr_bank_q];
    out_valid_s = full_q[rd_bank_q];
    wr_fire_s   = bus.in_valid & in_ready_s;
    rd_fire_s   = out_valid_s & bus.out_ready;
  end

  // Map the read counter to a (row, col) position and fetch that sample.
  always_comb begin
    if (READ_COL_MAJOR) begin
      rd_row_s = rd_idx_q[2:0];
      rd_col_s = rd_idx_q[5:3];
    end else begin
      rd_row_s = rd_idx_q[5:3];
      rd_col_s = rd_idx_q[2:0];
    end
    rd_data_s = mem_q[{rd_bank_q, rd_row_s, rd_col_s}];
  end

  // Next-state logic for the pointers, full flags, done pulse and occupancy.
  // A write completion and a read completion in the same cycle always target
  // different banks, so both flag updates can be applied independently.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    if (wr_fire_s) begin
      wr_idx_d = wr_idx_q + 6'd1;
      if (wr_idx_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end
    if (rd_fire_s) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_bank_d = rd_bank_q;
      end
    end else begin
      rd_idx_d = rd_idx_q;
    end
    block_done_d = rd_fire_s & (rd_idx_q == 6'd63);
    occupancy_d  = {1'b0, full_d[0]} + {1'b0, full_d[1]};
  end

  // Control state, cleared asynchronously; partial blocks are simply forgotten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_idx_q     <= 6'd0;
      rd_idx_q     <= 6'd0;
      block_done_q <= 1'b0;
      occupancy_q  <= 2'd0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      block_done_q <= block_done_d;
      occupancy_q  <= occupancy_d;
    end
  end

  // Sample storage: write the accepted sample at its raster position.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_q[{wr_bank_q, wr_idx_q}] <= {bus.in_y, bus.in_cb, bus.in_cr};
    end
  end

  // Drive the bus; data and position fields are forced to zero when nothing is valid.
  always_comb begin
    bus.in_ready   = in_ready_s;
    bus.out_valid  = out_valid_s;
    bus.block_done = block_done_q;
    bus.occupancy  = occupancy_q;
    if (out_valid_s) begin
      bus.out_y    = rd_data_s[2*DATA_W +: DATA_W];
      bus.out_cb   = rd_data_s[DATA_W +: DATA_W];
      bus.out_cr   = rd_data_s[0 +: DATA_W];
      bus.out_row  = rd_row_s;
      bus.out_col  = rd_col_s;
      bus.out_last = (rd_idx_q == 6'd63);
    end else begin
      bus.out_y    = {DATA_W{1'b0}};
      bus.out_cb   = {DATA_W{1'b0}};
      bus.out_cr   = {DATA_W{1'b0}};
      bus.out_row  = 3'd0;
      bus.out_col  = 3'd0;
      bus.out_last = 1'b0;
    end
  end
endmodule

// File: tb/tb_block_buffer_8x8.sv
// tb_block_buffer_8x8: drives a row-major and a column-major instance with the
// same input stream. Each instance is compared every cycle against a queue-based
// model of complete blocks waiting to be read.
module tb_block_buffer_8x8;
  localparam int DW = 8;
  typedef logic [3*DW-1:0] smp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_y, in_cb, in_cr;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: part_q is the block being written. blk_q holds completed
  // blocks in raster order, 64 entries each. The front block is being read.
  smp_t part_q[$];
  smp_t blk_q[$];
  int   rd_n;
  bit   done_m;

  always #5 clk = ~clk;

  block_buffer_8x8_if #(.DATA_W(DW)) bus_r ();
  block_buffer_8x8_if #(.DATA_W(DW)) bus_c ();

  assign bus_r.in_valid  = in_valid;
  assign bus_r.in_y      = in_y;
  assign bus_r.in_cb     = in_cb;
  assign bus_r.in_cr     = in_cr;
  assign bus_r.out_ready = out_ready;
  assign bus_c.in_valid  = in_valid;
  assign bus_c.in_y      = in_y;
  assign bus_c.in_cb     = in_cb;
  assign bus_c.in_cr     = in_cr;
  assign bus_c.out_ready = out_ready;

  block_buffer_8x8 #(.DATA_W(DW), .READ_COL_MAJOR(1'b0)) dut_row (.clk(clk), .rst(rst), .bus(bus_r));
  block_buffer_8x8 #(.DATA_W(DW), .READ_COL_MAJOR(1'b1)) dut_col (.clk(clk), .rst(rst), .bus(bus_c));

  function automatic void model_reset();
    part_q.delete();
    blk_q.delete();
    rd_n   = 0;
    done_m = 1'b0;
  endfunction

  // Expected {in_ready, out_valid, out_last, row, col, y, cb, cr, block_done, occupancy}.
  function automatic logic [35:0] expect_bus(input bit col_major);
    bit   rdy, vld, last;
    int   r, c;
    smp_t s;
    rdy  = (blk_q.size() < 128);
    vld  = (blk_q.size() > 0);
    r    = 0;
    c    = 0;
    s    = '0;
    last = 1'b0;
    if (vld) begin
      if (col_major) begin
        r = rd_n % 8;
        c = rd_n / 8;
      end else begin
        r = rd_n / 8;
        c = rd_n % 8;
      end
      s    = blk_q[r * 8 + c];
      last = (rd_n == 63);
    end
    return {rdy, vld, last, 3'(r), 3'(c), s, done_m, 2'(blk_q.size() / 64)};
  endfunction

  function automatic logic [35:0] observe(input bit col_major);
    if (col_major)
      return {bus_c.in_ready, bus_c.out_valid, bus_c.out_last, bus_c.out_row, bus_c.out_col,
              bus_c.out_y, bus_c.out_cb, bus_c.out_cr, bus_c.block_done, bus_c.occupancy};
    else
      return {bus_r.in_ready, bus_r.out_valid, bus_r.out_last, bus_r.out_row, bus_r.out_col,
              bus_r.out_y, bus_r.out_cb, bus_r.out_cr, bus_r.block_done, bus_r.occupancy};
  endfunction

  task automatic drive(input bit v, input smp_t s, input bit rdy);
    in_valid  = v;
    {in_y, in_cb, in_cr} = s;
    out_ready = rdy;
  endtask

  // Clock edge. The model applies the handshakes the specification says occur.
  task automatic advance();
    bit w, r;
    w = in_valid && (blk_q.size() < 128);
    r = (blk_q.size() > 0) && out_ready;
    @(posedge clk);
    done_m = r && (rd_n == 63);
    if (r) begin
      rd_n++;
      if (rd_n == 64) begin
        rd_n = 0;
        for (int k = 0; k < 64; k++) void'(blk_q.pop_front());
      end
    end
    if (w) begin
      part_q.push_back({in_y, in_cb, in_cr});
      if (part_q.size() == 64) begin
        foreach (part_q[k]) blk_q.push_back(part_q[k]);
        part_q.delete();
      end
    end
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 69; i++) begin
      drive(1'b1, smp_t'($urandom), 1'b0);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL reset_fill dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      advance();
    end
    // Reset asserted mid-cycle must take effect without waiting for a clock edge.
    #2;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (observe(d[0]) !== {1'b1, 35'd0}) begin
        n_err++;
        $display("FAIL reset_async dut=%0d got=%h exp=%h", d, observe(d[0]), {1'b1, 35'd0});
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_block();
    int outs_c = 0;
    for (int i = 0; i < 134; i++) begin
      if (i < 64) drive(1'b1, {8'(i - 64), 8'(-i), 8'(i - 32)}, 1'b1);
      else        drive(1'b0, '0, 1'b1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL single dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      if (bus_c.out_valid) begin
        if (outs_c == 1) begin
          n_vec++;
          if ({bus_c.out_y, bus_c.out_row, bus_c.out_col} !== {8'hC8, 3'd1, 3'd0}) begin
            n_err++;
            $display("FAIL col_second got=%h exp=%h", {bus_c.out_y, bus_c.out_row, bus_c.out_col}, {8'hC8, 3'd1, 3'd0});
          end
        end
        outs_c++;
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int   acc = 0;
    smp_t s   = smp_t'($urandom);
    for (int i = 0; i < 280; i++) begin
      drive(acc < 130, s, i >= 140);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL backpressure dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      if (i == 139) begin
        n_vec++;
        if ({bus_r.in_ready, bus_r.occupancy} !== {1'b0, 2'd2}) begin
          n_err++;
          $display("FAIL bp_full got=%b exp=%b", {bus_r.in_ready, bus_r.occupancy}, {1'b0, 2'd2});
        end
      end
      if (in_valid && blk_q.size() < 128) begin
        acc++;
        s = smp_t'($urandom);
      end
      advance();
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    int done_cyc[$];
    for (int i = 0; i < 262; i++) begin
      drive(i < 192, smp_t'($urandom), 1'b1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL b2b dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      if (bus_r.block_done) done_cyc.push_back(cyc);
      advance();
    end
    n_vec++;
    if (done_cyc.size() != 3) begin
      n_err++;
      $display("FAIL b2b_done_count got=%0d exp=3", done_cyc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        n_vec++;
        if (done_cyc[k] - done_cyc[k-1] != 64) begin
          n_err++;
          $display("FAIL b2b_done_gap got=%0d exp=64", done_cyc[k] - done_cyc[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_block();
    int nout  = 0;
    int ndone = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, smp_t'($urandom), 1'b1);
      advance();
    end
    apply_reset();
    for (int i = 0; i < 140; i++) begin
      drive(i < 64, smp_t'($urandom), 1'b1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL mid_reset dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      if (bus_r.out_valid && out_ready) nout++;
      if (bus_r.block_done) ndone++;
      advance();
    end
    n_vec++;
    if (nout != 64 || ndone != 1) begin
      n_err++;
      $display("FAIL mid_reset_count got=%0d/%0d exp=64/1", nout, ndone);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      drive($urandom_range(3, 0) != 0, smp_t'($urandom), $urandom_range(4, 0) > 1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (observe(d[0]) !== expect_bus(d[0])) begin
          n_err++;
          $display("FAIL random dut=%0d cyc=%0d got=%h exp=%h", d, cyc, observe(d[0]), expect_bus(d[0]));
        end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/block_buffer_8x8.md
Name: block_buffer_8x8

Overview:
- Sits directly downstream of the level shifter and upstream of the 2-D DCT.
- Collects level-shifted signed Y/Cb/Cr samples, arriving in raster order within an 8x8 block, into a ping-pong buffer of two banks.
- Replays each completed block to the DCT, in row-major or column-major order, over a valid/ready stream.
- One bank can be filled while the other is drained, so sustained throughput is one sample per cycle.

Parameters:
- DATA_W, 8, width of each signed component sample.
- READ_COL_MAJOR, 0, read order: 0 = row-major (idx = row*8+col); 1 = column-major (idx = col*8+row).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  buffer can accept a sample.
- in_y  in  DATA_W  signed Y sample.
- in_cb  in  DATA_W  signed Cb sample.
- in_cr  in  DATA_W  signed Cr sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts sample.
- out_y  out  DATA_W  signed Y sample.
- out_cb  out  DATA_W  signed Cb sample.
- out_cr  out  DATA_W  signed Cr sample.
- out_row  out  3  row index (0-7) of the current output sample.
- out_col  out  3  column index (0-7) of the current output sample.
- out_last  out  1  high with the 64th sample of a block.
- block_done  out  1  one-cycle pulse after the last sample of a block is accepted.
- occupancy  out  2  number of full banks (0-2).

Behaviour:
- Storage: two banks, each 64 entries of {y,cb,cr} (3*DATA_W bits).
  - Per-bank full flags, registered.
  - wr_bank / rd_bank pointers (1 bit each); wr_idx / rd_idx counters (6 bits each).
- Reset (async, rst=1):
  - wr_bank=rd_bank=0, wr_idx=rd_idx=0, both full flags 0.
  - block_done=0, occupancy=0, out_valid=0, in_ready=1.
  - Bank contents are not reset.
- Output gating: out_y/out_cb/out_cr/out_row/out_col/out_last are driven 0 whenever out_valid=0.
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid & in_ready: store the sample at bank[wr_bank][wr_idx], then wr_idx++.
  - When wr_idx==63 is written: wr_idx wraps to 0, full[wr_bank] is set, wr_bank toggles.
  - When in_valid=0 or in_ready=0: no state change.
- Read side:
  - out_valid = full[rd_bank].
  - Output data is read combinationally from bank[rd_bank] at the address mapped from rd_idx per READ_COL_MAJOR.
  - out_row/out_col give the mapped position; out_last = out_valid & (rd_idx==63).
  - On out_valid & out_ready: rd_idx++.
  - When the handshake occurs at rd_idx==63: rd_idx wraps to 0, full[rd_bank] clears, rd_bank toggles, and block_done pulses high the next cycle.
  - out_valid=1 with out_ready=0: all output signals hold stable.
- Latency: the first sample of a block is presented (out_valid=1) the cycle after the 64th write handshake.
- Simultaneous events:
  - A write completion and a read completion in the same cycle always target different banks; both take effect.
  - occupancy is registered and updates as count(full flags); a same-cycle set and clear leave it unchanged.
- Throughput: with out_ready held at 1 and continuous input, in_ready never deasserts. A bank freed at the edge of cycle 128 is writable in cycle 128.
- Reset mid-operation: partial blocks on either side are discarded; the next accepted sample is block entry 0 of bank 0.
- No wrap-around of occupancy beyond 2: writes are blocked by in_ready.

Test Plan:
- Reset: assert rst mid-clock -> immediately in_ready=1, out_valid=0, occupancy=0, all outputs 0.
- Single block, row-major:
  - Stimulus: write 64 samples, y=i-64, cb=-i, cr=i-32 (i=0..63), out_ready=1.
  - Response: out_valid rises the cycle after the 64th write; outputs y=-64..-1 in order; out_last on y=-1 (row 7, col 7); block_done one cycle later.
- Column-major (READ_COL_MAJOR=1), same stimulus:
  - Output n has y = (n%8)*8 + n/8 - 64.
  - Second output: y=-56, row=1, col=0.
- Backpressure: out_ready=0, stream 130 samples -> in_ready drops after the 128th accept; occupancy=2; samples 129-130 are held until out_ready=1.
- Back-to-back: 3 blocks continuous, out_ready=1 -> in_ready stays 1 for all 192 cycles; 192 outputs in order; three block_done pulses, 64 cycles apart.
- Reset mid-block: 30 writes, pulse rst, then 64 new writes -> exactly one block out, containing only the new 64 samples.
